// File: rtl/snake_pkg.sv
// snake_pkg: direction/scancode constants, prefix-FSM states and key decode for the snake input path.
package snake_pkg;
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_ARR_UP = 8'h75;
    localparam logic [7:0] SC_ARR_DN = 8'h72;
    localparam logic [7:0] SC_ARR_LT = 8'h6B;
    localparam logic [7:0] SC_ARR_RT = 8'h74;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;
    // Returns {is_dir, is_pause, dir}; both flags low means the code is ignored.
    function automatic logic [3:0] decode_key(input logic ext, input logic [7:0] code);
        return ext ? (code == SC_ARR_UP ? {2'b10, DIR_UP} :
                      code == SC_ARR_DN ? {2'b10, DIR_DOWN} :
                      code == SC_ARR_LT ? {2'b10, DIR_LEFT} :
                      code == SC_ARR_RT ? {2'b10, DIR_RIGHT} : 4'b0000)
                   : (code == SC_W      ? {2'b10, DIR_UP} :
                      code == SC_S      ? {2'b10, DIR_DOWN} :
                      code == SC_A      ? {2'b10, DIR_LEFT} :
                      code == SC_D      ? {2'b10, DIR_RIGHT} :
                      code == SC_SPACE  ? 4'b0100 : 4'b0000);
    endfunction
endpackage

// File: rtl/snake_dir_decoder_fifo.sv
// dir_fifo: DEPTH x 2-bit synchronous FIFO exposing head, tail and occupancy.
module dir_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RESETn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [1:0]                 din,
    output logic [1:0]                 head,
    output logic [1:0]                 tail,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr, tptr;
    always_comb begin
        tptr  = wptr - AW'(1);
        head  = mem[rptr];
        tail  = mem[tptr];
        full  = count == CW'(DEPTH);
        empty = count == '0;
    end
    always_ff @(posedge CLK)
        if (push) mem[wptr] <= din;
    always_ff @(posedge CLK or negedge RESETn)
        if (!RESETn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
endmodule

// File: rtl/snake_dir_decoder.sv
// snake_dir_decoder: PS/2 prefix resolution, typematic filter and reversal-checked direction queue.
module snake_dir_decoder
    import snake_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RESETn,
    input  logic [7:0]                 scancode,
    input  logic                       strobe,
    input  logic                       tick,
    output logic [1:0]                 dir,
    output logic                       dir_change,
    output logic                       pause_pulse,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       overflow
);
    state_t     state;
    logic       held_vld, mk, acc, want, push, pop, full, empty;
    logic [8:0] held, cur;
    logic [3:0] key;
    logic [1:0] head, tail, ref_dir;
    always_comb begin
        mk      = strobe && (state == ST_IDLE || state == ST_EXT) && scancode != SC_EXT && scancode != SC_BRK;
        cur     = {state == ST_EXT, scancode};
        key     = decode_key(cur[8], scancode);
        acc     = mk && key[3:2] != 2'b00 && !(held_vld && held == cur);
        ref_dir = empty ? dir : tail;
        want    = acc && key[3] && key[1:0] != ref_dir && key[1:0] != (ref_dir ^ 2'b01);
        pop     = tick && !empty;
        push    = want && (!full || pop);
    end
    dir_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK(CLK), .RESETn(RESETn), .push(push), .pop(pop), .din(key[1:0]),
        .head(head), .tail(tail), .count(q_count), .full(full), .empty(empty)
    );
    always_ff @(posedge CLK or negedge RESETn)
        if (!RESETn) begin
            state       <= ST_IDLE;
            held_vld    <= 1'b0;
            held        <= '0;
            dir         <= DIR_RIGHT;
            dir_change  <= 1'b0;
            pause_pulse <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            dir_change  <= pop;
            pause_pulse <= acc && key[2];
            if (pop) dir <= head;
            if (want && !push) overflow <= 1'b1;
            if (acc) begin
                held_vld <= 1'b1;
                held     <= cur;
            end
            if (strobe)
                case (state)
                    ST_IDLE: state <= scancode == SC_EXT ? ST_EXT : scancode == SC_BRK ? ST_BRK : ST_IDLE;
                    ST_EXT:  state <= scancode == SC_BRK ? ST_EXT_BRK : scancode == SC_EXT ? ST_EXT : ST_IDLE;
                    default: begin
                        // Break only releases the key if it matches the held make, ext flag included.
                        if (held_vld && held == {state == ST_EXT_BRK, scancode}) held_vld <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
        end
endmodule

// File: tb/tb_snake_dir_decoder.sv
// tb_snake_dir_decoder: directed plus randomized checks against a queue-based reference model.
module tb_snake_dir_decoder;
    localparam int DEPTH = 4;
    logic       CLK = 1'b0, RESETn = 1'b0, strobe = 1'b0, tick = 1'b0;
    logic [7:0] scancode = '0;
    logic [1:0] dir;
    logic       dir_change, pause_pulse, overflow;
    logic [$clog2(DEPTH+1)-1:0] q_count;
    int checks = 0, failures = 0;

    snake_dir_decoder #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESETn(RESETn), .scancode(scancode), .strobe(strobe), .tick(tick),
        .dir(dir), .dir_change(dir_change), .pause_pulse(pause_pulse),
        .q_count(q_count), .overflow(overflow)
    );
    always #5 CLK = ~CLK;

    int  mode;
    bit  hv, hext;
    int  hcode;
    int  q[$];
    int  mdir;
    bit  mchg, mpause, movf;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mode = 0; hv = 0; hext = 0; hcode = 0; q.delete();
        mdir = 3; mchg = 0; mpause = 0; movf = 0;
    endfunction

    // mode: 0 plain, 1 after E0, 2 after F0, 3 after E0 F0
    function automatic void model_step(input bit s, input int c, input bit t);
        int d, r;
        bit p, ext, popq;
        mchg = 0; mpause = 0;
        popq = t && q.size() > 0;
        if (s) begin
            if (mode >= 2) begin
                if (hv && hext == (mode == 3) && hcode == c) hv = 0;
                mode = 0;
            end else if (c == 'hE0) mode = 1;
            else if (c == 'hF0) mode = (mode == 1) ? 3 : 2;
            else begin
                ext = (mode == 1); mode = 0; d = -1; p = 0;
                if (ext) begin
                    if (c == 'h75) d = 0; else if (c == 'h72) d = 1;
                    else if (c == 'h6B) d = 2; else if (c == 'h74) d = 3;
                end else begin
                    if (c == 'h1D) d = 0; else if (c == 'h1B) d = 1;
                    else if (c == 'h1C) d = 2; else if (c == 'h23) d = 3;
                    else if (c == 'h29) p = 1;
                end
                if ((d >= 0 || p) && !(hv && hext == ext && hcode == c)) begin
                    hv = 1; hext = ext; hcode = c; mpause = p;
                    if (d >= 0) begin
                        r = q.size() > 0 ? q[$] : mdir;
                        if (d != r && d != (r ^ 1)) begin
                            if (q.size() < DEPTH || popq) q.push_back(d);
                            else movf = 1;
                        end
                    end
                end
            end
        end
        if (popq) begin
            mdir = q.pop_front();
            mchg = 1;
        end
    endfunction

    task automatic compare_all(input string tag);
        chk({tag, ".dir"}, int'(dir), mdir);
        chk({tag, ".dir_change"}, int'(dir_change), int'(mchg));
        chk({tag, ".pause"}, int'(pause_pulse), int'(mpause));
        chk({tag, ".q_count"}, int'(q_count), q.size());
        chk({tag, ".overflow"}, int'(overflow), int'(movf));
    endtask

    task automatic step(input bit s, input int c, input bit t, input string tag);
        @(negedge CLK);
        strobe = s; scancode = 8'(c); tick = t;
        @(posedge CLK);
        model_step(s, c, t);
        #1;
        compare_all(tag);
        strobe = 0; tick = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        RESETn = 0;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge CLK);
        RESETn = 1;
    endtask

    int pool[12] = '{'hE0, 'hF0, 'h75, 'h72, 'h6B, 'h74, 'h1D, 'h1B, 'h1C, 'h23, 'h29, 'h00};

    initial begin
        model_reset();
        #12;
        do_reset("rst0");
        step(1, 'hE0, 0, "ext_pre");
        step(1, 'h75, 0, "ext_up");
        chk("ext_up_count", int'(q_count), 1);
        step(0, 0, 1, "tick_up");
        chk("tick_up_dir", int'(dir), 0);
        chk("tick_up_chg", int'(dir_change), 1);
        step(0, 0, 0, "chg_drop");
        chk("chg_one_cycle", int'(dir_change), 0);

        do_reset("rst1");
        step(1, 'h1C, 0, "rev_left");
        step(1, 'h1D, 0, "w_up");
        step(1, 'h1B, 0, "s_down_rev");
        chk("rev_count", int'(q_count), 1);
        repeat (3) step(1, 'h23, 0, "typematic_d");
        chk("typematic_count", int'(q_count), 2);
        step(1, 'hF0, 0, "brk_pre");
        step(1, 'h23, 0, "brk_d");
        step(1, 'h23, 0, "d_eq_tail");
        chk("eq_tail_count", int'(q_count), 2);

        do_reset("rst2");
        for (int i = 0; i < 5; i++) step(1, (i % 2) ? 'h1C : 'h1D, 0, "fill");
        chk("full_count", int'(q_count), DEPTH);
        chk("full_ovf", int'(overflow), 1);
        step(1, 'h1B, 1, "push_pop_full");
        chk("push_pop_count", int'(q_count), DEPTH);
        step(1, 'h29, 0, "pause");
        chk("pause_pulse", int'(pause_pulse), 1);
        step(1, 'hF0, 0, "pause_brk_pre");
        step(1, 'h29, 0, "pause_brk");
        chk("pause_brk_none", int'(pause_pulse), 0);

        step(1, 'hE0, 0, "pre_reset_ext");
        do_reset("rst_mid");
        step(1, 'h75, 0, "fresh_75");
        chk("fresh_count", int'(q_count), 0);
        chk("fresh_dir", int'(dir), 3);

        for (int n = 0; n < 3000; n++) begin
            int c;
            c = pool[$urandom_range(0, 11)];
            if (c == 0) c = int'($urandom_range(0, 255));
            if (n == 1500) do_reset("rst_rand");
            step($urandom_range(0, 9) < 6, c, $urandom_range(0, 3) == 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
